// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: FSM state encoding, memory read latency, byte type,
// and the plaintext alphabet bounds also used by the decrypt-side checker.
package rc4_pkg;

  localparam int unsigned RD_LAT = 2;

  typedef logic [7:0] byte_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SET_I,
    ST_WAIT_SI1,
    ST_WAIT_SI2,
    ST_CALC_J,
    ST_WAIT_SJ1,
    ST_WAIT_SJ2,
    ST_SWAP_J,
    ST_SWAP_I,
    ST_CALC_F,
    ST_WAIT_F1,
    ST_WAIT_F2,
    ST_XOR_WR,
    ST_NEXT,
    ST_DONE,
    ST_ABORTED
  } state_t;

  localparam byte_t ALPHA_LO = 8'h61;
  localparam byte_t ALPHA_HI = 8'h7A;
  localparam byte_t ALPHA_SP = 8'h20;

endpackage

// File: rtl/rc4_encrypt_fsm_prga_step.sv
// RC4 PRGA index/swap datapath: holds i, j and the two swapped S values,
// and exposes the addresses the sequencer needs for each step.
module rc4_prga_step
  import rc4_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_step_i,
  input  logic       i_load_si,
  input  logic       i_load_sj,
  input  logic [7:0] i_s_q,
  output logic [7:0] o_i,
  output logic [7:0] o_i_next,
  output logic [7:0] o_j_next,
  output logic [7:0] o_si,
  output logic [7:0] o_sj,
  output logic [7:0] o_f
);

  byte_t r_i;
  byte_t r_j;
  byte_t r_si;
  byte_t r_sj;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i  <= '0;
      r_j  <= '0;
      r_si <= '0;
      r_sj <= '0;
    end else if (i_clr) begin
      r_i  <= '0;
      r_j  <= '0;
      r_si <= '0;
      r_sj <= '0;
    end else begin
      if (i_step_i) begin
        r_i <= r_i + 8'd1;
      end
      if (i_load_si) begin
        r_si <= i_s_q;
        r_j  <= r_j + i_s_q;
      end
      if (i_load_sj) begin
        r_sj <= i_s_q;
      end
    end
  end

  // All index arithmetic wraps mod 256 through the 8-bit result width.
  assign o_i      = r_i;
  assign o_i_next = r_i + 8'd1;
  assign o_j_next = r_j + i_s_q;
  assign o_si     = r_si;
  assign o_sj     = r_sj;
  assign o_f      = r_si + r_sj;

endmodule

// File: rtl/rc4_encrypt_fsm.sv
// RC4 PRGA encryptor: reads plaintext bytes, XORs each with one keystream byte
// taken from the preloaded S memory, and writes the ciphertext RAM.
module rc4_encrypt_fsm
  import rc4_pkg::*;
#(
  parameter int unsigned MSG_LEN = 32,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        s_q,
  input  logic [7:0]        pt_q,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_wren,
  output logic [ADDR_W-1:0] pt_address,
  output logic              pt_rden,
  output logic [ADDR_W-1:0] ct_address,
  output logic [7:0]        ct_data,
  output logic              ct_wren,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(MSG_LEN - 1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_k, w_k_nxt;
  logic [7:0]        r_s_address, w_s_address_nxt;
  logic [7:0]        r_s_data, w_s_data_nxt;
  logic              r_s_wren, w_s_wren_nxt;
  logic [ADDR_W-1:0] r_pt_address, w_pt_address_nxt;
  logic              r_pt_rden, w_pt_rden_nxt;
  logic [ADDR_W-1:0] r_ct_address, w_ct_address_nxt;
  logic [7:0]        r_ct_data, w_ct_data_nxt;
  logic              r_ct_wren, w_ct_wren_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_aborted, w_aborted_nxt;

  logic       w_clr;
  logic       w_step_i;
  logic       w_load_si;
  logic       w_load_sj;
  logic [7:0] w_i;
  logic [7:0] w_i_next;
  logic [7:0] w_j_next;
  logic [7:0] w_si;
  logic [7:0] w_sj;
  logic [7:0] w_f;

  rc4_prga_step u_step (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_clr),
    .i_step_i  (w_step_i),
    .i_load_si (w_load_si),
    .i_load_sj (w_load_sj),
    .i_s_q     (s_q),
    .o_i       (w_i),
    .o_i_next  (w_i_next),
    .o_j_next  (w_j_next),
    .o_si      (w_si),
    .o_sj      (w_sj),
    .o_f       (w_f)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_k          <= '0;
      r_s_address  <= '0;
      r_s_data     <= '0;
      r_s_wren     <= 1'b0;
      r_pt_address <= '0;
      r_pt_rden    <= 1'b0;
      r_ct_address <= '0;
      r_ct_data    <= '0;
      r_ct_wren    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_k          <= w_k_nxt;
      r_s_address  <= w_s_address_nxt;
      r_s_data     <= w_s_data_nxt;
      r_s_wren     <= w_s_wren_nxt;
      r_pt_address <= w_pt_address_nxt;
      r_pt_rden    <= w_pt_rden_nxt;
      r_ct_address <= w_ct_address_nxt;
      r_ct_data    <= w_ct_data_nxt;
      r_ct_wren    <= w_ct_wren_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_aborted    <= w_aborted_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_k_nxt          = r_k;
    w_s_address_nxt  = r_s_address;
    w_s_data_nxt     = r_s_data;
    w_s_wren_nxt     = r_s_wren;
    w_pt_address_nxt = r_pt_address;
    w_pt_rden_nxt    = r_pt_rden;
    w_ct_address_nxt = r_ct_address;
    w_ct_data_nxt    = r_ct_data;
    w_ct_wren_nxt    = r_ct_wren;
    w_busy_nxt       = r_busy;
    w_done_nxt       = r_done;
    w_aborted_nxt    = r_aborted;
    w_clr            = 1'b0;
    w_step_i         = 1'b0;
    w_load_si        = 1'b0;
    w_load_sj        = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_clr            = 1'b1;
        w_k_nxt          = '0;
        w_s_address_nxt  = '0;
        w_s_data_nxt     = '0;
        w_s_wren_nxt     = 1'b0;
        w_pt_address_nxt = '0;
        w_pt_rden_nxt    = 1'b0;
        w_ct_address_nxt = '0;
        w_ct_data_nxt    = '0;
        w_ct_wren_nxt    = 1'b0;
        w_busy_nxt       = 1'b0;
        w_done_nxt       = 1'b0;
        w_aborted_nxt    = 1'b0;
        if (start) begin
          w_state_nxt = ST_SET_I;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_SET_I: begin
        w_step_i         = 1'b1;
        w_s_address_nxt  = w_i_next;
        w_pt_address_nxt = r_k;
        w_pt_rden_nxt    = 1'b1;
        w_state_nxt      = ST_WAIT_SI1;
      end
      ST_WAIT_SI1: w_state_nxt = ST_WAIT_SI2;
      ST_WAIT_SI2: w_state_nxt = ST_CALC_J;
      ST_CALC_J: begin
        w_load_si       = 1'b1;
        w_s_address_nxt = w_j_next;
        w_state_nxt     = ST_WAIT_SJ1;
      end
      ST_WAIT_SJ1: w_state_nxt = ST_WAIT_SJ2;
      ST_WAIT_SJ2: w_state_nxt = ST_SWAP_J;
      // S[j] <= si is written while SWAP_I is current, S[i] <= sj while CALC_F is.
      ST_SWAP_J: begin
        w_load_sj    = 1'b1;
        w_s_data_nxt = w_si;
        w_s_wren_nxt = 1'b1;
        w_state_nxt  = ST_SWAP_I;
      end
      ST_SWAP_I: begin
        w_s_address_nxt = w_i;
        w_s_data_nxt    = w_sj;
        w_state_nxt     = ST_CALC_F;
      end
      ST_CALC_F: begin
        w_s_wren_nxt    = 1'b0;
        w_s_address_nxt = w_f;
        w_state_nxt     = ST_WAIT_F1;
      end
      ST_WAIT_F1: w_state_nxt = ST_WAIT_F2;
      ST_WAIT_F2: w_state_nxt = ST_XOR_WR;
      ST_XOR_WR: begin
        w_ct_address_nxt = r_k;
        w_ct_data_nxt    = s_q ^ pt_q;
        w_ct_wren_nxt    = 1'b1;
        w_state_nxt      = ST_NEXT;
      end
      ST_NEXT: begin
        w_ct_wren_nxt = 1'b0;
        w_pt_rden_nxt = 1'b0;
        w_k_nxt       = r_k + ADDR_W'(1);
        if (r_k == K_LAST) begin
          w_state_nxt = ST_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else if (abort) begin
          w_state_nxt   = ST_ABORTED;
          w_busy_nxt    = 1'b0;
          w_aborted_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_SET_I;
        end
      end
      ST_DONE: begin
        if (!start) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b0;
        end
      end
      ST_ABORTED: begin
        if (!start) begin
          w_state_nxt   = ST_IDLE;
          w_aborted_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign s_address  = r_s_address;
  assign s_data     = r_s_data;
  assign s_wren     = r_s_wren;
  assign pt_address = r_pt_address;
  assign pt_rden    = r_pt_rden;
  assign ct_address = r_ct_address;
  assign ct_data    = r_ct_data;
  assign ct_wren    = r_ct_wren;
  assign busy       = r_busy;
  assign done       = r_done;
  assign aborted    = r_aborted;

endmodule

// File: tb/tb_rc4_encrypt_fsm.sv
// Bench for rc4_encrypt_fsm: memory models around the DUT and an array-based
// RC4 reference that predicts ciphertext and final S contents per run.
module tb_rc4_encrypt_fsm;
  import rc4_pkg::*;

  localparam int unsigned MSG_LEN = 9;
  localparam int unsigned ADDR_W  = 5;
  localparam int          RUN_LAT = 1 + 13 * MSG_LEN;

  logic              clk = 1'b0;
  logic              reset, start, abort;
  logic [7:0]        s_q, pt_q, s_address, s_data, ct_data;
  logic              s_wren, pt_rden, ct_wren, busy, done, aborted;
  logic [ADDR_W-1:0] pt_address, ct_address;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rc4_encrypt_fsm #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .s_q        (s_q),
    .pt_q       (pt_q),
    .s_address  (s_address),
    .s_data     (s_data),
    .s_wren     (s_wren),
    .pt_address (pt_address),
    .pt_rden    (pt_rden),
    .ct_address (ct_address),
    .ct_data    (ct_data),
    .ct_wren    (ct_wren),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  byte_t s_mem  [256];
  byte_t s_init [256];
  byte_t pt_rom [32];
  byte_t ct_mem [32];
  byte_t s_pipe [RD_LAT];
  byte_t p_pipe [RD_LAT];
  logic  load_req = 1'b0;
  int    ct_wr_cnt = 0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int a = 0; a < 256; a++) s_mem[a] <= s_init[a];
      for (int a = 0; a < 32; a++) ct_mem[a] <= 8'h00;
      ct_wr_cnt <= 0;
    end else begin
      if (s_wren) s_mem[s_address] <= s_data;
      if (ct_wren) begin
        ct_mem[ct_address] <= ct_data;
        ct_wr_cnt <= ct_wr_cnt + 1;
      end
    end
    s_pipe[0] <= s_mem[s_address];
    for (int p = 1; p < RD_LAT; p++) s_pipe[p] <= s_pipe[p-1];
    if (pt_rden) begin
      p_pipe[0] <= pt_rom[pt_address];
      for (int p = 1; p < RD_LAT; p++) p_pipe[p] <= p_pipe[p-1];
    end
  end

  assign s_q  = s_pipe[RD_LAT-1];
  assign pt_q = p_pipe[RD_LAT-1];

  byte_t m_s  [256];
  byte_t m_ct [32];
  byte_t key_b [3];
  byte_t saved_ct [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_run(input int n);
    int    i = 0;
    int    j = 0;
    byte_t t;
    for (int a = 0; a < 256; a++) m_s[a] = s_init[a];
    for (int k = 0; k < n; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(m_s[i])) % 256;
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      m_ct[k] = pt_rom[k] ^ m_s[(int'(m_s[i]) + int'(m_s[j])) % 256];
    end
  endtask

  task automatic load_identity();
    for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
  endtask

  task automatic load_ksa();
    int    j = 0;
    byte_t t;
    load_identity();
    for (int a = 0; a < 256; a++) begin
      j = (j + int'(s_init[a]) + int'(key_b[a % 3])) % 256;
      t = s_init[a]; s_init[a] = s_init[j]; s_init[j] = t;
    end
  endtask

  task automatic load_perm();
    int    r;
    byte_t t;
    load_identity();
    for (int a = 255; a > 0; a--) begin
      r = int'($urandom_range(a, 0));
      t = s_init[a]; s_init[a] = s_init[r]; s_init[r] = t;
    end
  endtask

  task automatic rand_plain();
    for (int k = 0; k < 32; k++)
      pt_rom[k] = ($urandom_range(7, 0) == 0) ? ALPHA_SP : 8'($urandom_range(ALPHA_HI, ALPHA_LO));
  endtask

  task automatic mem_load();
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
  endtask

  // Starts a run, waits (bounded) for done/aborted, optionally raises abort at a cycle.
  task automatic run_msg(input int abort_at, input int hold, output int lat);
    start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 5) chk("busy_mid_run", 32'(busy), 32'd1);
      if (lat == abort_at) abort = 1'b1;
    end while (!done && !aborted && lat < 4000);
    chk("run_terminates", 32'(done | aborted), 32'd1);
    chk("busy_after_end", 32'(busy), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("held_flag", 32'(done | aborted), 32'd1);
      chk("held_no_write", 32'(ct_wren), 32'd0);
    end
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("flags_clear", 32'({busy, done, aborted}), 32'd0);
  endtask

  task automatic cmp_ct(input string tag, input int n);
    for (int k = 0; k < n; k++) chk(tag, 32'(ct_mem[k]), 32'(m_ct[k]));
  endtask

  task automatic cmp_s(input string tag);
    int bad = 0;
    for (int a = 0; a < 256; a++) if (s_mem[a] !== m_s[a]) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    int    lat;
    int    seen;
    byte_t plain [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    byte_t kv_ct [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

    reset = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_addr", 32'(s_address), 32'd0);
    chk("rst_wrens", 32'({s_wren, ct_wren, pt_rden}), 32'd0);
    chk("rst_flags", 32'({busy, done, aborted}), 32'd0);
    chk("rst_addrs", 32'({pt_address, ct_address, ct_data, s_data}), 32'd0);
    reset = 1'b0;
    abort = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ignores_abort", 32'({busy, aborted}), 32'd0);
    abort = 1'b0;

    // Identity S, all-zero plaintext.
    load_identity();
    for (int k = 0; k < 32; k++) pt_rom[k] = 8'h00;
    model_run(MSG_LEN);
    mem_load();
    run_msg(-1, 0, lat);
    chk("ident_latency", 32'(lat), 32'(RUN_LAT));
    chk("ident_ct0", 32'(ct_mem[0]), 32'h02);
    chk("ident_ct1", 32'(ct_mem[1]), 32'h05);
    cmp_ct("ident_ct", MSG_LEN);
    cmp_s("ident_s_final");
    chk("ident_wr_cnt", 32'(ct_wr_cnt), 32'(MSG_LEN));

    // Known-answer vector: key "Key", plaintext "Plaintext".
    key_b[0] = 8'h4B; key_b[1] = 8'h65; key_b[2] = 8'h79;
    load_ksa();
    for (int k = 0; k < 9; k++) pt_rom[k] = plain[k];
    model_run(MSG_LEN);
    mem_load();
    run_msg(-1, 0, lat);
    for (int k = 0; k < 9; k++) chk("kat_ct", 32'(ct_mem[k]), 32'(kv_ct[k]));
    cmp_ct("kat_model", MSG_LEN);
    cmp_s("kat_s_final");
    for (int k = 0; k < 9; k++) saved_ct[k] = ct_mem[k];

    // Round trip: the ciphertext re-encrypted under the same S gives the plaintext back.
    load_ksa();
    for (int k = 0; k < 9; k++) pt_rom[k] = saved_ct[k];
    mem_load();
    run_msg(-1, 0, lat);
    for (int k = 0; k < 9; k++) chk("roundtrip", 32'(ct_mem[k]), 32'(plain[k]));

    // Random S permutations and plaintexts.
    for (int r = 0; r < 3; r++) begin
      load_perm();
      rand_plain();
      model_run(MSG_LEN);
      mem_load();
      run_msg(-1, 0, lat);
      chk("rand_latency", 32'(lat), 32'(RUN_LAT));
      cmp_ct("rand_ct", MSG_LEN);
      cmp_s("rand_s_final");
    end

    // Abort raised during byte 3: bytes 0..3 written, aborted after byte 3's NEXT.
    load_perm();
    rand_plain();
    model_run(MSG_LEN);
    mem_load();
    run_msg(1 + 13 * 3 + 4, 3, lat);
    chk("abort_latency", 32'(lat), 32'(1 + 13 * 4));
    chk("abort_wr_cnt", 32'(ct_wr_cnt), 32'd4);
    cmp_ct("abort_partial", 4);
    chk("abort_byte4_untouched", 32'(ct_mem[4]), 32'h00);

    // Abort on the final byte: the run still completes.
    load_perm();
    rand_plain();
    model_run(MSG_LEN);
    mem_load();
    run_msg(1 + 13 * (MSG_LEN - 1) + 4, 0, lat);
    chk("abort_last_latency", 32'(lat), 32'(RUN_LAT));
    chk("abort_last_wr_cnt", 32'(ct_wr_cnt), 32'(MSG_LEN));
    cmp_ct("abort_last_ct", MSG_LEN);

    // Reset pulsed during SWAP_I (first cycle s_wren is high).
    load_perm();
    rand_plain();
    mem_load();
    start = 1'b1;
    seen = 0;
    for (int c = 0; c < 200 && seen == 0; c++) begin
      @(negedge clk);
      if (s_wren) seen = 1;
    end
    chk("swap_reached", 32'(seen), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_wrens", 32'({s_wren, ct_wren, pt_rden}), 32'd0);
    chk("arst_outs", 32'({s_address, s_data, busy, done, aborted}), 32'd0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_run(MSG_LEN);
    mem_load();
    run_msg(-1, 0, lat);
    chk("post_rst_latency", 32'(lat), 32'(RUN_LAT));
    cmp_ct("post_rst_ct", MSG_LEN);
    cmp_s("post_rst_s_final");

    // start held high after done: no restart, then a fresh run.
    load_perm();
    rand_plain();
    model_run(MSG_LEN);
    mem_load();
    run_msg(-1, 20, lat);
    chk("hold_wr_cnt", 32'(ct_wr_cnt), 32'(MSG_LEN));
    cmp_ct("hold_ct", MSG_LEN);
    load_perm();
    rand_plain();
    model_run(MSG_LEN);
    mem_load();
    run_msg(-1, 0, lat);
    chk("fresh_latency", 32'(lat), 32'(RUN_LAT));
    cmp_ct("fresh_ct", MSG_LEN);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rc4_encrypt_fsm.md
Name: rc4_encrypt_fsm

Overview:
RC4 PRGA encryptor. S-box memory is preloaded by the KSA stage. The block reads MSG_LEN plaintext bytes from a plaintext ROM and generates one keystream byte per message byte. It XORs each pair and writes the result to a ciphertext RAM. It is the transmit-side counterpart of the decrypt cores: same S-memory port timing, same i/j/k counter scheme, no plaintext validity check.

Parameters:
MSG_LEN, 32, number of message bytes processed per run (1..32).
ADDR_W, 5, width of plaintext/ciphertext address buses.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  level; sampled in IDLE to begin a run
abort  in  1  level; terminates the run at the next byte boundary
s_q  in  8  S-memory read data
pt_q  in  8  plaintext ROM read data
s_address  out  8  S-memory address
s_data  out  8  S-memory write data
s_wren  out  1  S-memory write enable
pt_address  out  ADDR_W  plaintext ROM address
pt_rden  out  1  plaintext ROM read enable
ct_address  out  ADDR_W  ciphertext RAM address
ct_data  out  8  ciphertext byte
ct_wren  out  1  ciphertext RAM write enable
busy  out  1  high from leaving IDLE until DONE/ABORTED
done  out  1  run completed; held until start low
aborted  out  1  run aborted; held until start low

Behaviour:
- Reset (async, active-high):
  - state=IDLE; i, j, k=0.
  - All outputs 0.
- All outputs are registered.
- Memory timing: read data is valid and sampled 2 cycles after the cycle in which the address output changes. A write occurs on the edge after s_wren/ct_wren is registered high with address and data.
- IDLE:
  - Outputs idle; i, j, k cleared.
  - start=1 -> SET_I, busy<=1.
- Per-byte sequence, 13 cycles/byte:
  - SET_I: i<=i+1; s_address<=i+1; pt_address<=k; pt_rden<=1.
  - WAIT_SI1 -> WAIT_SI2.
  - CALC_J: si<=s_q; j<=j+s_q (mod 256); s_address<=j+s_q.
  - WAIT_SJ1 -> WAIT_SJ2.
  - SWAP_J: sj<=s_q; s_data<=si; s_wren<=1 (writes S[j]=si).
  - SWAP_I: s_address<=i; s_data<=sj; s_wren stays 1.
  - CALC_F: s_wren<=0; s_address<=si+sj (mod 256).
  - WAIT_F1 -> WAIT_F2.
  - XOR_WR: ct_address<=k; ct_data<=s_q^pt_q; ct_wren<=1.
  - NEXT: ct_wren<=0; pt_rden<=0; k<=k+1.
    - If k==MSG_LEN-1 -> DONE.
    - Else if abort -> ABORTED.
    - Else -> SET_I.
- Arithmetic: i, j and the f index are all 8-bit mod 256. i wraps 255->0 without special handling. k is never compared beyond MSG_LEN-1.
- i==j: the same address is written twice with the same value; S is unchanged; no special case.
- DONE: busy<=0; done<=1; hold while start=1. start=0 -> IDLE with done<=0.
- ABORTED: same handshake as DONE, using aborted.
- abort is ignored in IDLE.
- The final byte completes (done wins) if abort rises on the last byte.
- A partial ciphertext (bytes 0..k) remains valid after an abort.
- Reset mid-run returns to IDLE immediately. Any in-flight write is dropped (wren cleared asynchronously). S contents are then undefined and the KSA stage must rerun.
- Total latency from start to done: 1 + 13*MSG_LEN cycles.

Decomposition:
- Package rc4_pkg:
  - State enum.
  - RD_LAT=2 constant.
  - Byte typedef.
  - Alphabet constants shared with the decrypt checker.
- Optional sub-module rc4_prga_step: the i/j/swap/f datapath (registers si, sj, i, j; computes f index). Shared with a future refactor of the decrypt core.
- The top-level FSM owns the plaintext/ciphertext sequencing and the handshake.

Test Plan:
- Identity S (S[x]=x), MSG_LEN=2, plaintext 00 00 -> ciphertext 02 05; S[2]=3 and S[3]=2 afterwards; done at cycle 27 after start.
- S preloaded from KSA with key 4B 65 79 ("Key"), MSG_LEN=9, plaintext "Plaintext" -> ciphertext BB F3 16 E8 D9 40 AF 0A D3.
- Round trip: encrypt "attack at dawn" padded to 32 bytes, reload the same KSA S, feed the ciphertext as plaintext -> original bytes; the decrypt core on the ciphertext reports success.
- abort raised during byte 3 -> bytes 0..3 written; aborted=1, busy=0; no ct_wren after NEXT; aborted clears one cycle after start=0.
- reset pulsed mid-SWAP_I -> s_wren and ct_wren drop asynchronously; all outputs 0; next start runs from i=j=k=0.
- start held high after done -> no restart; done stays 1 until start=0, then IDLE; a new start pulse begins a fresh run.
